dbg_reg_bank: RTL and testbench
===============================

Name: dbg_reg_bank

Overview:
- Register bank directly downstream of the UART register-interface stage.
- Consumes its byte-addressed write/read strobes and returns read data with a done pulse.
- Hosts the debugger test sequencer: launches tests, captures results and enforces a timeout.
- Sits between the UART command decoder and the debugger/test engine.

Parameters:
- ID_VALUE, 32'hDB600001, constant returned by the ID register.
- RD_LATENCY, 1, cycles from reg_rd_en to reg_rd_done; legal range 1..4.
- TIMEOUT_DEFAULT, 32'd1000000, reset value of the TIMEOUT register.

Ports:
- core_clk  in  1  single clock.
- core_rst_n  in  1  asynchronous, active-low reset.
- reg_addr  in  8  register index.
- reg_wr_data  in  32  write data.
- reg_wr_en  in  1  single-cycle write strobe.
- reg_rd_en  in  1  single-cycle read strobe.
- reg_rd_data  out  32  read data; valid while reg_rd_done=1.
- reg_rd_done  out  1  one-cycle read completion pulse.
- start_test  out  1  one-cycle test launch pulse.
- test_command  out  32  current TEST_CMD register value.
- test_result  in  32  result from the test engine.
- test_result_valid  in  1  one-cycle result strobe.
- test_busy  out  1  sequencer is in RUN.

Behaviour:
- Register map (index, access):
  - 0x00 ID (RO): returns ID_VALUE.
  - 0x01 SCRATCH (RW).
  - 0x02 CTRL (WO): bit0 = start; bit1 = clear sticky flags and RESULT_CNT; reads 0.
  - 0x03 TEST_CMD (RW).
  - 0x04 STATUS (RO): {28'd0, overrun, timeout, done, busy}.
  - 0x05 RESULT (RO).
  - 0x06 TIMEOUT (RW).
  - 0x07 RESULT_CNT (RO): 16-bit count, zero-extended.
- Reset values:
  - reg_rd_data=0, reg_rd_done=0, start_test=0, test_busy=0.
  - SCRATCH=0, TEST_CMD=0 (so test_command=0), RESULT=0, RESULT_CNT=0.
  - TIMEOUT=TIMEOUT_DEFAULT; all flags 0; sequencer in IDLE.
- Writes:
  - A write takes effect on the clock edge where reg_wr_en=1.
  - Writes to RO or unmapped indices are silently ignored.
- Reads:
  - Register contents are sampled in the reg_rd_en cycle, i.e. the pre-write value if a write to the same index occurs in that cycle.
  - The sample is delayed through a RD_LATENCY-stage pipeline; reg_rd_done pulses exactly RD_LATENCY cycles after reg_rd_en.
  - Back-to-back reads (reg_rd_en on consecutive cycles) are fully pipelined; each produces its own done pulse.
  - Unmapped index reads return 32'hDEADBEEF.
  - reg_rd_data holds its last value when reg_rd_done=0.
- Sequencer FSM, states IDLE, RUN, DONE:
  - IDLE: a CTRL write with bit0=1 asserts start_test the next cycle, loads the down-counter from TIMEOUT, clears done/timeout and goes to RUN.
  - RUN: test_busy=1; the counter decrements every cycle.
    - On test_result_valid: RESULT<=test_result, RESULT_CNT+=1 (wraps at 16'hFFFF to 0), done<=1, go to DONE.
    - If the counter reaches 0 before that: timeout<=1, go to IDLE.
  - DONE: returns to IDLE the next cycle.
- Boundary conditions:
  - test_result_valid and timeout expiry in the same cycle: the result wins.
  - Start write while in RUN: ignored, overrun<=1.
  - test_result_valid while in IDLE: RESULT is not updated, overrun<=1.
  - TIMEOUT=0: the test times out one cycle after start.
  - TEST_CMD writes in RUN are accepted; the test engine samples test_command only on start_test.
  - CTRL bit1 and bit0 set together: clear first, then start.
  - Reset asserted mid-operation: all state returns to reset values immediately; pipelined reads are dropped with no done pulse.

Optional Feature:
- Macro: DBG_REG_BANK_ERR_CNT_EN.
- Defined:
  - Index 0x08 ERR_CNT (RO) counts writes to RO/unmapped indices plus reads of unmapped indices.
  - 16-bit count, saturating at 16'hFFFF, zero-extended on read.
  - Cleared by CTRL bit1.
- Undefined: index 0x08 is unmapped and reads 32'hDEADBEEF.

Decomposition:
- Shared package dbg_reg_pkg holds:
  - register index constants;
  - STATUS bit positions;
  - sequencer state enum;
  - the 32'hDEADBEEF unmapped-read constant.
- One sub-module, dbg_rd_pipe: parameterised RD_LATENCY data/valid delay line with asynchronous reset.

Test Plan:
- Read ID after reset, RD_LATENCY=2 -> reg_rd_done 2 cycles after reg_rd_en, data 32'hDB600001.
- Write SCRATCH=32'h12345678, read it back -> 32'h12345678; write ID=0 then read ID -> still 32'hDB600001.
- TEST_CMD=32'hA5, CTRL=1, test_result=32'hCAFE after 10 cycles -> one start_test pulse, test_command=32'hA5, STATUS=0x2, RESULT=32'hCAFE, RESULT_CNT=1.
- TIMEOUT=5, CTRL=1, no result -> timeout set once the counter reaches 0 after the start (5-cycle counter), test_busy drops, STATUS=0x4.
- Second start during RUN, plus a test_result_valid arriving in the expiry cycle -> overrun set, result captured, timeout=0.
- Assert core_rst_n low during RUN with a read in flight -> all outputs return to reset values, no reg_rd_done; with ERR_CNT_EN, a read of index 0x1F then ERR_CNT -> 1.

Source files
------------

// File: rtl/dbg_reg_pkg.sv
// Shared definitions for the debug register bank: register indices,
// STATUS bit positions, sequencer states and the unmapped-read pattern.
package dbg_reg_pkg;

   localparam logic [7:0] IDX_ID      = 8'h00;
   localparam logic [7:0] IDX_SCRATCH = 8'h01;
   localparam logic [7:0] IDX_CTRL    = 8'h02;
   localparam logic [7:0] IDX_TESTCMD = 8'h03;
   localparam logic [7:0] IDX_STATUS  = 8'h04;
   localparam logic [7:0] IDX_RESULT  = 8'h05;
   localparam logic [7:0] IDX_TIMEOUT = 8'h06;
   localparam logic [7:0] IDX_RESCNT  = 8'h07;
   localparam logic [7:0] IDX_ERRCNT  = 8'h08;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_DONE    = 1;
   localparam int unsigned ST_TIMEOUT = 2;
   localparam int unsigned ST_OVERRUN = 3;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_CLEAR = 1;

   localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_e;

   function automatic logic [31:0] zext16(input logic [15:0] v);
      return {16'd0, v};
   endfunction

endpackage

// File: rtl/dbg_reg_bank_if.sv
// Register-access bus between the UART register-interface stage (master)
// and the debug register bank (slave).
interface dbg_reg_bank_if;

   logic [7:0]  reg_addr;
   logic [31:0] reg_wr_data;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [31:0] reg_rd_data;
   logic        reg_rd_done;

   modport master (
      output reg_addr,
      output reg_wr_data,
      output reg_wr_en,
      output reg_rd_en,
      input  reg_rd_data,
      input  reg_rd_done
   );

   modport slave (
      input  reg_addr,
      input  reg_wr_data,
      input  reg_wr_en,
      input  reg_rd_en,
      output reg_rd_data,
      output reg_rd_done
   );

endinterface

// File: rtl/dbg_rd_pipe.sv
// LAT-stage read-data/valid delay line; each stage only reloads its data
// when valid moves in, so the output holds the last completed read.
module dbg_rd_pipe #(
   parameter int unsigned LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        vld_i,
   input  logic [31:0] data_i,
   output logic        vld_o,
   output logic [31:0] data_o
);

   logic        vld_q  [LAT];
   logic [31:0] data_q [LAT];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(LAT); i++) begin
            vld_q[i]  <= 1'b0;
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= vld_i;
         if (vld_i) data_q[0] <= data_i;
         for (int i = 1; i < int'(LAT); i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[LAT-1];
   assign data_o = data_q[LAT-1];

endmodule

// File: rtl/dbg_reg_bank.sv
// Debug register bank with test sequencer (IDLE/RUN/DONE) and timeout.
// Optional ERR_CNT register at 0x08 under `DBG_REG_BANK_ERR_CNT_EN.
module dbg_reg_bank
   import dbg_reg_pkg::*;
#(
   parameter logic [31:0] ID_VALUE        = 32'hDB600001,
   parameter int unsigned RD_LATENCY      = 1,
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1000000
) (
   input  logic                 core_clk,
   input  logic                 core_rst_n,
   dbg_reg_bank_if.slave        reg_bus,
   output logic                 start_test,
   output logic [31:0]          test_command,
   input  logic [31:0]          test_result,
   input  logic                 test_result_valid,
   output logic                 test_busy
);

   seq_state_e  state_q, state_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] cmd_q, cmd_d;
   logic [31:0] result_q, result_d;
   logic [31:0] tmo_q, tmo_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] rcnt_q, rcnt_d;
   logic        done_q, done_d;
   logic        tflag_q, tflag_d;
   logic        ovr_q, ovr_d;
   logic        start_q, start_d;

   logic        wr_ctrl, start_req, clr_req, expire;
   logic [31:0] rd_mux;
   logic [31:0] status;

`ifdef DBG_REG_BANK_ERR_CNT_EN
   logic [15:0] err_q, err_d;
   logic        wr_bad, rd_bad;
`endif

   assign wr_ctrl   = reg_bus.reg_wr_en && (reg_bus.reg_addr == IDX_CTRL);
   assign start_req = wr_ctrl && reg_bus.reg_wr_data[CTRL_START];
   assign clr_req   = wr_ctrl && reg_bus.reg_wr_data[CTRL_CLEAR];
   // Counter values 1 and 0 both mean "hits zero this cycle".
   assign expire    = (cnt_q <= 32'd1);

   always_comb begin
      scratch_d = scratch_q;
      cmd_d     = cmd_q;
      tmo_d     = tmo_q;
      if (reg_bus.reg_wr_en) begin
         unique case (reg_bus.reg_addr)
            IDX_SCRATCH: scratch_d = reg_bus.reg_wr_data;
            IDX_TESTCMD: cmd_d     = reg_bus.reg_wr_data;
            IDX_TIMEOUT: tmo_d     = reg_bus.reg_wr_data;
            default:     ;
         endcase
      end
   end

   // Clear is applied before sequencer events so "clear+start" works.
   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      cnt_d    = cnt_q;
      result_d = result_q;
      rcnt_d   = clr_req ? 16'd0 : rcnt_q;
      done_d   = clr_req ? 1'b0 : done_q;
      tflag_d  = clr_req ? 1'b0 : tflag_q;
      ovr_d    = clr_req ? 1'b0 : ovr_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (test_result_valid) ovr_d = 1'b1;
            if (start_req) begin
               start_d = 1'b1;
               cnt_d   = tmo_q;
               done_d  = 1'b0;
               tflag_d = 1'b0;
               state_d = SEQ_RUN;
            end
         end
         SEQ_RUN: begin
            if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
            if (start_req) ovr_d = 1'b1;
            if (test_result_valid) begin
               result_d = test_result;
               rcnt_d   = rcnt_d + 16'd1;
               done_d   = 1'b1;
               state_d  = SEQ_DONE;
            end else if (expire) begin
               tflag_d = 1'b1;
               state_d = SEQ_IDLE;
            end
         end
         SEQ_DONE: state_d = SEQ_IDLE;
         default:  state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q   <= SEQ_IDLE;
         scratch_q <= '0;
         cmd_q     <= '0;
         result_q  <= '0;
         tmo_q     <= TIMEOUT_DEFAULT;
         cnt_q     <= '0;
         rcnt_q    <= '0;
         done_q    <= 1'b0;
         tflag_q   <= 1'b0;
         ovr_q     <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         scratch_q <= scratch_d;
         cmd_q     <= cmd_d;
         result_q  <= result_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         done_q    <= done_d;
         tflag_q   <= tflag_d;
         ovr_q     <= ovr_d;
         start_q   <= start_d;
      end
   end

`ifdef DBG_REG_BANK_ERR_CNT_EN
   always_comb begin
      wr_bad = 1'b0;
      if (reg_bus.reg_wr_en) begin
         unique case (reg_bus.reg_addr)
            IDX_SCRATCH, IDX_CTRL, IDX_TESTCMD, IDX_TIMEOUT: wr_bad = 1'b0;
            default: wr_bad = 1'b1;
         endcase
      end
      rd_bad = reg_bus.reg_rd_en && (reg_bus.reg_addr > IDX_ERRCNT);
      err_d  = clr_req ? 16'd0 : err_q;
      if ((wr_bad || rd_bad) && (err_d != 16'hFFFF)) err_d = err_d + 16'd1;
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) err_q <= '0;
      else             err_q <= err_d;
   end
`endif

   always_comb begin
      status              = '0;
      status[ST_BUSY]     = (state_q == SEQ_RUN);
      status[ST_DONE]     = done_q;
      status[ST_TIMEOUT]  = tflag_q;
      status[ST_OVERRUN]  = ovr_q;
   end

   always_comb begin
      rd_mux = UNMAPPED_DATA;
      unique case (reg_bus.reg_addr)
         IDX_ID:      rd_mux = ID_VALUE;
         IDX_SCRATCH: rd_mux = scratch_q;
         IDX_CTRL:    rd_mux = 32'd0;
         IDX_TESTCMD: rd_mux = cmd_q;
         IDX_STATUS:  rd_mux = status;
         IDX_RESULT:  rd_mux = result_q;
         IDX_TIMEOUT: rd_mux = tmo_q;
         IDX_RESCNT:  rd_mux = zext16(rcnt_q);
`ifdef DBG_REG_BANK_ERR_CNT_EN
         IDX_ERRCNT:  rd_mux = zext16(err_q);
`endif
         default:     rd_mux = UNMAPPED_DATA;
      endcase
   end

   dbg_rd_pipe #(
      .LAT (RD_LATENCY)
   ) u_rd_pipe (
      .clk_i  (core_clk),
      .rst_ni (core_rst_n),
      .vld_i  (reg_bus.reg_rd_en),
      .data_i (rd_mux),
      .vld_o  (reg_bus.reg_rd_done),
      .data_o (reg_bus.reg_rd_data)
   );

   assign start_test   = start_q;
   assign test_command = cmd_q;
   assign test_busy    = (state_q == SEQ_RUN);

endmodule

// File: tb/tb_dbg_reg_bank.sv
// Directed bench for dbg_reg_bank with RD_LATENCY=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dbg_reg_bank;
   import dbg_reg_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] test_result;
   logic        test_result_valid;
   logic        start_test;
   logic [31:0] test_command;
   logic        test_busy;

   int n_cmp = 0;
   int n_err = 0;

   dbg_reg_bank_if bus ();

   dbg_reg_bank #(
      .ID_VALUE        (32'hDB600001),
      .RD_LATENCY      (2),
      .TIMEOUT_DEFAULT (32'd1000000)
   ) dut (
      .core_clk          (clk),
      .core_rst_n        (rst_n),
      .reg_bus           (bus),
      .start_test        (start_test),
      .test_command      (test_command),
      .test_result       (test_result),
      .test_result_valid (test_result_valid),
      .test_busy         (test_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.reg_addr    = a;
      bus.reg_wr_data = d;
      bus.reg_wr_en   = 1'b1;
      @(negedge clk);
      bus.reg_wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d,
                     output int lat);
      bus.reg_addr  = a;
      bus.reg_rd_en = 1'b1;
      lat = -1;
      d   = 'x;
      for (int n = 1; n <= 8 && lat < 0; n++) begin
         @(negedge clk);
         bus.reg_rd_en = 1'b0;
         bus.reg_wr_en = 1'b0;
         if (bus.reg_rd_done) begin
            lat = n;
            d   = bus.reg_rd_data;
         end
      end
   endtask

   task automatic rchk(input string tag, input logic [7:0] a,
                       input logic [31:0] exp);
      logic [31:0] d;
      int          lat;
      rd(a, d, lat);
      chk(tag, d, exp);
   endtask

   task automatic busy_len(input string tag, input int exp);
      int n = 0;
      while (test_busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   task automatic pulse_result(input logic [31:0] r);
      test_result       = r;
      test_result_valid = 1'b1;
      @(negedge clk);
      test_result_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          lat;
      int          seen;

      rst_n             = 1'b0;
      bus.reg_addr      = '0;
      bus.reg_wr_data   = '0;
      bus.reg_wr_en     = 1'b0;
      bus.reg_rd_en     = 1'b0;
      test_result       = '0;
      test_result_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rd_data", bus.reg_rd_data, 32'h0);
      chk("rst_rd_done", 32'(bus.reg_rd_done), 32'h0);
      chk("rst_start", 32'(start_test), 32'h0);
      chk("rst_busy", 32'(test_busy), 32'h0);
      chk("rst_cmd", test_command, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      rd(IDX_ID, d, lat);
      chk("id_data", d, 32'hDB600001);
      chk("id_latency", 32'(lat), 32'd2);
      rchk("timeout_rst", IDX_TIMEOUT, 32'd1000000);
      rchk("status_rst", IDX_STATUS, 32'h0);

      wr(IDX_SCRATCH, 32'h12345678);
      rchk("scratch_rw", IDX_SCRATCH, 32'h12345678);
      wr(IDX_ID, 32'h0);
      rchk("id_ro", IDX_ID, 32'hDB600001);
      rchk("ctrl_rd0", IDX_CTRL, 32'h0);
      rchk("unmapped", 8'h1F, 32'hDEADBEEF);
`ifdef DBG_REG_BANK_ERR_CNT_EN
      rchk("errcnt_2", IDX_ERRCNT, 32'd2);
`else
      rchk("idx8_unmap", IDX_ERRCNT, 32'hDEADBEEF);
`endif

      // back-to-back reads, then hold of last data
      bus.reg_addr  = IDX_ID;
      bus.reg_rd_en = 1'b1;
      @(negedge clk);
      bus.reg_addr  = IDX_SCRATCH;
      @(negedge clk);
      bus.reg_rd_en = 1'b0;
      chk("b2b_done0", 32'(bus.reg_rd_done), 32'h1);
      chk("b2b_data0", bus.reg_rd_data, 32'hDB600001);
      @(negedge clk);
      chk("b2b_done1", 32'(bus.reg_rd_done), 32'h1);
      chk("b2b_data1", bus.reg_rd_data, 32'h12345678);
      @(negedge clk);
      chk("b2b_idle", 32'(bus.reg_rd_done), 32'h0);
      chk("b2b_hold", bus.reg_rd_data, 32'h12345678);

      // same-cycle write and read returns the old value
      bus.reg_wr_data = 32'h0BADF00D;
      bus.reg_wr_en   = 1'b1;
      rd(IDX_SCRATCH, d, lat);
      chk("rd_pre_wr", d, 32'h12345678);
      rchk("rd_post_wr", IDX_SCRATCH, 32'h0BADF00D);

      // normal test run
      wr(IDX_TESTCMD, 32'hA5);
      wr(IDX_CTRL, 32'h1);
      chk("run_start", 32'(start_test), 32'h1);
      chk("run_cmd", test_command, 32'hA5);
      chk("run_busy", 32'(test_busy), 32'h1);
      @(negedge clk);
      chk("run_start1", 32'(start_test), 32'h0);
      repeat (9) @(negedge clk);
      chk("run_busy10", 32'(test_busy), 32'h1);
      pulse_result(32'hCAFE);
      chk("run_idle", 32'(test_busy), 32'h0);
      rchk("run_status", IDX_STATUS, 32'h2);
      rchk("run_result", IDX_RESULT, 32'hCAFE);
      rchk("run_rescnt", IDX_RESCNT, 32'd1);

      // timeout after 5 cycles
      wr(IDX_TIMEOUT, 32'd5);
      wr(IDX_CTRL, 32'h1);
      busy_len("tmo5_len", 5);
      rchk("tmo5_status", IDX_STATUS, 32'h4);
      rchk("tmo5_result", IDX_RESULT, 32'hCAFE);

      // TIMEOUT=0 expires one cycle after start
      wr(IDX_TIMEOUT, 32'd0);
      wr(IDX_CTRL, 32'h1);
      busy_len("tmo0_len", 1);
      rchk("tmo0_status", IDX_STATUS, 32'h4);

      // overrun start plus result in the expiry cycle
      wr(IDX_TIMEOUT, 32'd4);
      wr(IDX_CTRL, 32'h1);
      wr(IDX_CTRL, 32'h1);
      chk("ovr_nostart", 32'(start_test), 32'h0);
      repeat (2) @(negedge clk);
      pulse_result(32'h00BEEF01);
      rchk("ovr_status", IDX_STATUS, 32'hA);
      rchk("ovr_result", IDX_RESULT, 32'h00BEEF01);
      rchk("ovr_rescnt", IDX_RESCNT, 32'd2);

      // clear, then a stray result in IDLE
      wr(IDX_CTRL, 32'h2);
      rchk("clr_status", IDX_STATUS, 32'h0);
      rchk("clr_rescnt", IDX_RESCNT, 32'd0);
      pulse_result(32'h1111);
      rchk("idle_res_st", IDX_STATUS, 32'h8);
      rchk("idle_res_r", IDX_RESULT, 32'h00BEEF01);

      // clear and start together
      wr(IDX_CTRL, 32'h3);
      chk("cs_start", 32'(start_test), 32'h1);
      rchk("cs_status", IDX_STATUS, 32'h1);
      busy_len("cs_drain", 2);

      // reset during RUN with a read in flight
      wr(IDX_TIMEOUT, 32'd100);
      wr(IDX_CTRL, 32'h1);
      bus.reg_addr  = IDX_SCRATCH;
      bus.reg_rd_en = 1'b1;
      @(negedge clk);
      bus.reg_rd_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_done", 32'(bus.reg_rd_done), 32'h0);
      chk("mrst_data", bus.reg_rd_data, 32'h0);
      chk("mrst_start", 32'(start_test), 32'h0);
      chk("mrst_busy", 32'(test_busy), 32'h0);
      chk("mrst_cmd", test_command, 32'h0);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.reg_rd_done) seen++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.reg_rd_done) seen++;
      end
      chk("mrst_nodone", 32'(seen), 32'd0);
      rchk("mrst_scratch", IDX_SCRATCH, 32'h0);
      rchk("mrst_tmo", IDX_TIMEOUT, 32'd1000000);
      rchk("mrst_status", IDX_STATUS, 32'h0);
      rchk("mrst_result", IDX_RESULT, 32'h0);
      rchk("mrst_unmap", 8'h1F, 32'hDEADBEEF);
`ifdef DBG_REG_BANK_ERR_CNT_EN
      rchk("mrst_errcnt", IDX_ERRCNT, 32'd1);
`else
      rchk("mrst_idx8", IDX_ERRCNT, 32'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
